// File: rtl/cla_adder_pipe.sv
// -----------------------------------------------------------------------------
// cla_adder_pipe
//   Pipelined carry-lookahead adder/subtractor. The operands are cut into
//   SEG-bit segments. Stage k adds segment k with 4-bit lookahead groups and
//   registers its carry for stage k+1. Operand segments are skewed on the way
//   in and result segments are deskewed on the way out, so every sum bit of
//   one operation leaves on the same cycle.
//
//   Latency is STAGES = WIDTH/SEG enabled edges. The accepting edge counts as
//   the first of them. Throughput is one operation per enabled cycle.
//
// Parameters
//   WIDTH     operand/result width, a multiple of SEG
//   SEG       bits resolved per stage, a multiple of 4
//
// Ports
//   clk       clock, rising edge
//   rst       synchronous active-high reset, takes priority over en
//   en        advance enable; 0 holds every register
//   in_valid  a/b/cin/sub carry an operation this cycle
//   a, b      operands
//   cin       carry-in to bit 0, used as given
//   sub       0: a+b+cin, 1: a+~b+cin
//   out_valid sum/cout/ovf hold a completed operation
//   sum       registered result (mod 2^WIDTH)
//   cout      registered carry out of bit WIDTH-1
//   ovf       registered signed overflow
//
// Build option
//   CLA_PIPE_OVF_EN : when defined, ovf reports signed overflow. It is
//                     computed in the last stage and registered with sum.
//                     When undefined, ovf is tied to 0.
// -----------------------------------------------------------------------------
module cla_adder_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG;
  localparam int GROUPS = SEG / 4;

  // One 4-bit lookahead group. Returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] x,
                                      input logic [3:0] y,
                                      input logic       c0);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c[4], p ^ c[3:0]};
  endfunction

  // Combinational stage outputs, gathered so that a single register block
  // owns each piece of state.
  logic [STAGES-1:0] seg_cout;
  logic [WIDTH-1:0]  seg_sum;

  // carry_q[k] is the carry registered out of stage k.
  logic [STAGES-1:0] carry_q;

  // valid_q[j] belongs to the operation that has passed j enabled edges.
  logic [STAGES:1]   valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
    end else if (en) begin
      valid_q[1] <= in_valid;
      for (int j = 2; j <= STAGES; j++) begin
        valid_q[j] <= valid_q[j-1];
      end
      carry_q <= seg_cout;
    end
  end

  assign out_valid = valid_q[STAGES];
  assign cout      = carry_q[STAGES-1];

`ifdef CLA_PIPE_OVF_EN
  // Sign bits of A and effective B for the operation now in the last stage.
  // They reach that stage inside the last segment's skew registers.
  logic top_sign_a;
  logic top_sign_beff;
  logic ovf_q;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    localparam int DLY = STAGES - 1 - k;

    logic [SEG-1:0] a_seg;
    logic [SEG-1:0] b_seg;
    logic           sub_seg;
    logic           c_in;
    logic [SEG-1:0] beff;
    logic [SEG-1:0] res;
    logic           c_out;

    if (k == 0) begin : g_in
      assign a_seg   = a[SEG-1:0];
      assign b_seg   = b[SEG-1:0];
      assign sub_seg = sub;
      assign c_in    = cin;
    end else begin : g_in
      // Input skew: k registers so that this segment meets the carry of
      // its own operation coming out of stage k-1.
      logic [SEG-1:0] a_q [1:k];
      logic [SEG-1:0] b_q [1:k];
      logic [k:1]     sub_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 1; j <= k; j++) begin
            a_q[j] <= '0;
            b_q[j] <= '0;
          end
          sub_q <= '0;
        end else if (en) begin
          a_q[1]   <= a[k*SEG +: SEG];
          b_q[1]   <= b[k*SEG +: SEG];
          sub_q[1] <= sub;
          for (int j = 2; j <= k; j++) begin
            a_q[j]   <= a_q[j-1];
            b_q[j]   <= b_q[j-1];
            sub_q[j] <= sub_q[j-1];
          end
        end
      end

      assign a_seg   = a_q[k];
      assign b_seg   = b_q[k];
      assign sub_seg = sub_q[k];
      assign c_in    = carry_q[k-1];
    end

    assign beff = b_seg ^ {SEG{sub_seg}};

    // Lookahead inside each group, ripple between groups.
    always_comb begin
      logic c;
      c   = c_in;
      res = '0;
      for (int g = 0; g < GROUPS; g++) begin
        {c, res[g*4 +: 4]} = cla4(a_seg[g*4 +: 4], beff[g*4 +: 4], c);
      end
      c_out = c;
    end

    assign seg_sum[k*SEG +: SEG] = res;
    assign seg_cout[k]           = c_out;

    // Output deskew: res_q[0] is the stage register, and DLY more registers
    // follow so that all segments line up on the output.
    logic [SEG-1:0] res_q [0:DLY];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j <= DLY; j++) begin
          res_q[j] <= '0;
        end
      end else if (en) begin
        res_q[0] <= res;
        for (int j = 1; j <= DLY; j++) begin
          res_q[j] <= res_q[j-1];
        end
      end
    end

    assign sum[k*SEG +: SEG] = res_q[DLY];

`ifdef CLA_PIPE_OVF_EN
    if (k == STAGES - 1) begin : g_sign
      assign top_sign_a    = a_seg[SEG-1];
      assign top_sign_beff = beff[SEG-1];
    end
`endif
  end

`ifdef CLA_PIPE_OVF_EN
  // Overflow: both operands share a sign and the result sign differs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (en) begin
      ovf_q <= (top_sign_a == top_sign_beff) &&
               (seg_sum[WIDTH-1] != top_sign_a);
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cla_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_cla_adder_pipe
//   Directed bench for cla_adder_pipe at WIDTH=32, SEG=8 (latency 4).
//   Inputs are driven on the falling edge and outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_cla_adder_pipe;

  localparam int W = 32;
`ifdef CLA_PIPE_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_adder_pipe #(.WIDTH(W), .SEG(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v,
                           input logic [W-1:0] s, input logic c,
                           input logic o);
    check({tag, ".valid"}, 64'(out_valid), 64'(v));
    check({tag, ".sum"},   64'(sum),       64'(s));
    check({tag, ".cout"},  64'(cout),      64'(c));
    check({tag, ".ovf"},   64'(ovf),       64'(o));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic e, input logic v, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic c, input logic s);
    en       = e;
    in_valid = v;
    a        = av;
    b        = bv;
    cin      = c;
    sub      = s;
  endtask

  task automatic drive_idle();
    drive(1'b1, 1'b0, W'($urandom), W'($urandom), 1'b0, 1'b0);
  endtask

  // One isolated operation with hand-computed results: nothing for three
  // edges, the result on the fourth, then out_valid drops again.
  task automatic run_single(input string tag, input logic [W-1:0] av,
                            input logic [W-1:0] bv, input logic c,
                            input logic s, input logic [W-1:0] es,
                            input logic ec, input logic eo);
    drive(1'b1, 1'b1, av, bv, c, s);
    tick();
    drive_idle();
    check({tag, ".lat1"}, 64'(out_valid), 64'(0));
    tick();
    check({tag, ".lat2"}, 64'(out_valid), 64'(0));
    tick();
    check({tag, ".lat3"}, 64'(out_valid), 64'(0));
    tick();
    check_out(tag, 1'b1, es, ec, eo);
    tick();
    check({tag, ".once"}, 64'(out_valid), 64'(0));
  endtask

  // Reference pipeline for the stream test: four slots that shift on en.
  logic         m_v [4];
  logic [W-1:0] m_s [4];
  logic         m_c [4];
  logic         m_o [4];

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_v[i] = 1'b0;
      m_s[i] = '0;
      m_c[i] = 1'b0;
      m_o[i] = 1'b0;
    end
  endtask

  task automatic stream_step(input string tag, input logic e, input logic v,
                             input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic c, input logic s);
    logic [W-1:0] be;
    logic [W:0]   t;
    drive(e, v, av, bv, c, s);
    be = bv ^ {W{s}};
    t  = {1'b0, av} + {1'b0, be} + {{W{1'b0}}, c};
    tick();
    if (e) begin
      for (int i = 3; i > 0; i--) begin
        m_v[i] = m_v[i-1];
        m_s[i] = m_s[i-1];
        m_c[i] = m_c[i-1];
        m_o[i] = m_o[i-1];
      end
      m_v[0] = v;
      m_s[0] = t[W-1:0];
      m_c[0] = t[W];
      m_o[0] = OVF_ON & (av[W-1] == be[W-1]) & (t[W-1] != av[W-1]);
    end
    if (m_v[3]) check_out(tag, 1'b1, m_s[3], m_c[3], m_o[3]);
    else        check({tag, ".valid"}, 64'(out_valid), 64'(0));
  endtask

  logic [W-1:0] op_a   [6] = '{32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0000,
                               32'h0000_FFFF, 32'hDEAD_BEEF, 32'h7FFF_FFFF};
  logic [W-1:0] op_b   [6] = '{32'h9ABC_DEF0, 32'hFFFF_FFFF, 32'h0000_0001,
                               32'h0000_0001, 32'hDEAD_BEEF, 32'h7FFF_FFFF};
  logic         op_cin [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic         op_sub [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  // Stream schedule: {en, valid, op index}. Cycle 4 is a bubble and
  // cycles 6..8 stall while op1 sits on the output.
  int plan_en  [13] = '{1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
  int plan_vld [13] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0};
  int plan_idx [13] = '{0, 1, 2, 0, 3, 0, 0, 0, 4, 5, 0, 0, 0};

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b1, W'($urandom), W'($urandom), 1'b1, 1'b1);

    // Reset with live inputs, second cycle with en low.
    tick();
    check_out("rst1", 1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, W'($urandom), W'($urandom), 1'b1, 1'b0);
    tick();
    check_out("rst2", 1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    drive_idle();
    tick();
    check_out("rst_rel", 1'b0, '0, 1'b0, 1'b0);

    // Directed single operations.
    run_single("wrap_add", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
               32'h0000_0000, 1'b1, 1'b0);
    run_single("sub_5_7", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1,
               32'hFFFF_FFFE, 1'b0, 1'b0);
    run_single("sub_7_5", 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1,
               32'h0000_0002, 1'b1, 1'b0);
    run_single("ovf_add", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
               32'h8000_0000, 1'b0, OVF_ON);
    run_single("ovf_sub", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1,
               32'h7FFF_FFFF, 1'b1, OVF_ON);
    run_single("cin_chain", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0,
               32'h0000_0000, 1'b1, 1'b0);
    run_single("seg_carry", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0,
               32'h0100_0100, 1'b0, 1'b0);

    // Stream with a bubble and a three-cycle stall.
    model_clear();
    for (int i = 0; i < 13; i++) begin
      int idx;
      idx = plan_idx[i];
      if (plan_en[i] == 0)
        stream_step($sformatf("stream%0d", i), 1'b0, 1'b1,
                    W'($urandom), W'($urandom), 1'b1, 1'b1);
      else
        stream_step($sformatf("stream%0d", i), 1'b1, plan_vld[i] != 0,
                    op_a[idx], op_b[idx], op_cin[idx], op_sub[idx]);
    end

    // Reset while en is low still clears the valid result on the output.
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    check_out("rst_pri", 1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    drive_idle();
    tick();

    // Reset mid-stream: three ops accepted, a fourth presented on the
    // reset edge. None may emerge; the next op keeps normal latency.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, op_a[i], op_b[i], op_cin[i], op_sub[i]);
      tick();
      check($sformatf("mid_fill%0d.valid", i), 64'(out_valid), 64'(0));
    end
    rst = 1'b1;
    drive(1'b1, 1'b1, op_a[3], op_b[3], op_cin[3], op_sub[3]);
    tick();
    check_out("mid_rst", 1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    run_single("post_rst", 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0,
               32'h0000_0007, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("drain%0d.valid", i), 64'(out_valid), 64'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
